// File: rtl/mux8way_arbiter.sv
// mux8way_arbiter: round-robin owner of the Mux8way select; MUX8WAY_ARB_TIMEOUT_EN adds a HOLD_MAX rotation limit.
module mux8way_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [2:0] select,
  output logic [7:0] grant,
  output logic       valid,
  output logic [7:0] holdCount
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t r_state, w_state_n;
  logic [2:0] r_select, r_pointer, w_select_n, w_pointer_n, w_start, w_win;
  logic       w_force, w_keep, w_any;
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX out of range 2..255");
  end
  assign w_any  = |req;
  assign w_keep = (r_state == GRANT) && req[r_select] && !w_force;
`ifdef MUX8WAY_ARB_TIMEOUT_EN
  logic [7:0] r_hold;
  assign w_force = (r_state == GRANT) && req[r_select] && (r_hold == 8'(HOLD_MAX - 1));
  always_ff @(posedge clk)
    if (reset) r_hold <= 8'd0;
    else r_hold <= w_keep ? ((r_hold == 8'hFF) ? r_hold : r_hold + 8'd1) : 8'd0;
  assign holdCount = r_hold;
`else
  assign w_force   = 1'b0;
  assign holdCount = 8'd0;
`endif
  // A forced rotation searches past the current owner; otherwise resume from the pointer.
  always_comb begin
    w_start = w_force ? r_select + 3'd1 : r_pointer;
    w_win   = w_start;
    for (int k = 7; k >= 0; k--)
      if (req[w_start + 3'(k)]) w_win = w_start + 3'(k);
  end
  always_comb begin
    w_state_n   = r_state;
    w_select_n  = r_select;
    w_pointer_n = r_pointer;
    if (w_any && (r_state == IDLE || !w_keep)) begin
      w_state_n   = GRANT;
      w_select_n  = w_win;
      w_pointer_n = w_win + 3'd1;
    end else if (r_state == GRANT && !w_keep) begin
      w_state_n = IDLE;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state   <= IDLE;
      r_select  <= 3'd0;
      r_pointer <= 3'd0;
    end else begin
      r_state   <= w_state_n;
      r_select  <= w_select_n;
      r_pointer <= w_pointer_n;
    end
  assign select = r_select;
  assign valid  = (r_state == GRANT);
  assign grant  = valid ? (8'd1 << r_select) : 8'd0;
endmodule

// File: tb/tb_mux8way_arbiter.sv
// tb_mux8way_arbiter: directed plus random stimulus against an owner/pointer reference model.
module tb_mux8way_arbiter;
  localparam int HM = 4;
`ifdef MUX8WAY_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic       clk = 1'b0, reset = 1'b0;
  logic [7:0] req = 8'd0;
  logic [2:0] select;
  logic [7:0] grant, holdCount;
  logic       valid;
  int n_chk = 0, n_pass = 0;
  int m_owner = -1, m_sel = 0, m_ptr = 0, m_hold = 0;
  mux8way_arbiter #(.HOLD_MAX(HM)) dut (
    .clk(clk), .reset(reset), .req(req), .select(select),
    .grant(grant), .valid(valid), .holdCount(holdCount)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic int pick(input logic [7:0] r, input int s);
    for (int k = 0; k < 8; k++) if (r[(s + k) % 8]) return (s + k) % 8;
    return -1;
  endfunction
  task automatic model(input logic [7:0] r, input bit rs);
    int w;
    if (rs) begin
      m_owner = -1; m_sel = 0; m_ptr = 0; m_hold = 0;
      return;
    end
    if (m_owner >= 0 && r[m_owner] && !(TO && m_hold == HM - 1)) begin
      m_hold++;
      return;
    end
    if (r == 8'd0) begin
      m_owner = -1; m_hold = 0;
      return;
    end
    w = pick(r, (m_owner >= 0 && r[m_owner]) ? m_owner + 1 : m_ptr);
    m_owner = w; m_sel = w; m_ptr = (w + 1) % 8; m_hold = 0;
  endtask
  task automatic cyc(input logic [7:0] r, input bit rs = 1'b0);
    @(negedge clk);
    req = r; reset = rs;
    @(posedge clk);
    model(r, rs);
    #1;
    check("select", 32'(select), 32'(m_sel));
    check("valid", 32'(valid), 32'(m_owner >= 0));
    check("grant", 32'(grant), (m_owner >= 0) ? 32'(1) << m_sel : 32'd0);
    check("holdCount", 32'(holdCount), TO ? 32'(m_hold) : 32'd0);
  endtask
  initial begin
    logic [7:0] r;
    cyc(8'h00, 1'b1); cyc(8'h00, 1'b1);
    cyc(8'h10); cyc(8'h10); cyc(8'h00);
    for (int g = 0; g < 9; g++) begin
      cyc(8'hFF); cyc(8'hFF);
      r = 8'hFF;
      r[m_sel] = 1'b0;
      cyc(r);
    end
    cyc(8'h00, 1'b1);
    cyc(8'h81); cyc(8'h80); cyc(8'h00); cyc(8'h81); cyc(8'h00);
    cyc(8'h00, 1'b1);
    cyc(8'h08); cyc(8'h08); cyc(8'h00);
    cyc(8'h20); cyc(8'h20); cyc(8'h20, 1'b1); cyc(8'h20); cyc(8'h20);
    cyc(8'h00, 1'b1);
    for (int i = 0; i < 10; i++) cyc(8'h03);
    for (int i = 0; i < 10; i++) cyc(8'h01);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: r = 8'h00;
        1: r = 8'(1) << $urandom_range(0, 7);
        2: r = m_owner >= 0 ? 8'($urandom) | (8'(1) << m_owner) : 8'($urandom);
        default: r = 8'($urandom);
      endcase
      cyc(r, $urandom_range(0, 49) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
